// File: rtl/single_port_sram_controller.sv
// Single-port SRAM initiator: valid/ready requests in, cs/we/oe/address/tristate data out, read data back on a valid/ready response.
// Latency: write commits 1 cycle after acceptance; read response 3 edges after acceptance (acceptance edge counted as the first).
// Backpressure: req_ready only in IDLE; a pending response holds the FSM in RESP. SRAM_CTRL_WRITE_ACK_EN adds a write echo response.
module single_port_sram_controller #(
    parameter int  WIDTH      = 32,
    parameter int  DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [WIDTH-1:0]      sram_data,
    output logic                  sram_chip_select,
    output logic                  sram_write_enable,
    output logic                  sram_output_enable
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  capture;
    logic                  sample;
    logic                  drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state         = state;
        req_ready          = 1'b0;
        rsp_valid          = 1'b0;
        sram_chip_select   = 1'b0;
        sram_write_enable  = 1'b0;
        sram_output_enable = 1'b0;
        drive              = 1'b0;
        capture            = 1'b0;
        sample             = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    capture    = 1'b1;
                    next_state = req_write ? WRITE : RD_ADDR;
                end
            end
            WRITE: begin
                sram_chip_select  = 1'b1;
                sram_write_enable = 1'b1;
                drive             = 1'b1;
`ifdef SRAM_CTRL_WRITE_ACK_EN
                next_state        = RESP;
`else
                next_state        = IDLE;
`endif
            end
            RD_ADDR: begin
                sram_chip_select = 1'b1;
                next_state       = RD_DATA;
            end
            RD_DATA: begin
                // SRAM owns the bus here; address is still addr_q so its re-read is benign
                sram_chip_select   = 1'b1;
                sram_output_enable = 1'b1;
                sample             = 1'b1;
                next_state         = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
        end else if (sample) begin
            rsp_rdata <= sram_data;
`ifdef SRAM_CTRL_WRITE_ACK_EN
        end else if (state == WRITE) begin
            rsp_rdata <= wdata_q;
`endif
        end
    end

    assign sram_address = addr_q;
    assign sram_data    = drive ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_sram_controller.sv
module tb_single_port_sram_controller;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
`ifdef SRAM_CTRL_WRITE_ACK_EN
    localparam int WR_GAP = 3;
`else
    localparam int WR_GAP = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready, req_write;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic [AW-1:0]    sram_address;
    wire  [WIDTH-1:0] sram_data;
    logic             cs, we, oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    single_port_sram_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_address(sram_address), .sram_data(sram_data),
        .sram_chip_select(cs), .sram_write_enable(we), .sram_output_enable(oe)
    );

    // behavioural single-port SRAM: latches a read word at the edge, drives it while oe
    logic [WIDTH-1:0] sram_mem [DEPTH];
    logic [WIDTH-1:0] sram_dout;
    always @(posedge clk) begin
        if (cs) begin
            if (we) sram_mem[sram_address] <= sram_data;
            else    sram_dout <= sram_mem[sram_address];
        end
    end
    assign sram_data = (cs && oe && !we) ? sram_dout : {WIDTH{1'bz}};

    // reference memory: what every address must hold according to accepted writes
    logic [WIDTH-1:0] ref_mem [DEPTH];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bus ownership: oe only with cs and never with we, and read data must be defined
    always @(negedge clk) begin
        if (rst_n && (oe || we)) begin
            chk("bus_excl", {30'd0, oe, we}, oe ? 32'd2 : 32'd1);
            chk("bus_cs", {31'd0, cs}, 32'd1);
            if (oe) chk("bus_known", {31'd0, $isunknown(sram_data)}, 32'd0);
        end
    end

    task automatic wait_ready(input string name, output int waited);
        waited = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) chk({name, "_timeout"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic get_rsp(input logic [WIDTH-1:0] exp, input int stall);
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, exp);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_cs", {31'd0, cs}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, exp);
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, output int waited);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        wait_ready("wr", waited);
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
        ref_mem[a] = d;
        chk("wr_we", {31'd0, we}, 32'd1);
        chk("wr_cs", {31'd0, cs}, 32'd1);
        chk("wr_addr", {28'd0, sram_address}, {28'd0, a});
        chk("wr_busy", {31'd0, req_ready}, 32'd0);
        tick();
        chk("wr_we_1cyc", {31'd0, we}, 32'd0);
`ifdef SRAM_CTRL_WRITE_ACK_EN
        get_rsp(d, 0);
`else
        chk("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("wr_ready_again", {31'd0, req_ready}, 32'd1);
`endif
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int stall);
        int waited;
        logic [WIDTH-1:0] exp;
        exp = ref_mem[a];
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = $urandom;
        wait_ready("rd", waited);
        tick();                                  // acceptance edge (edge 1)
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = AW'($urandom);
        chk("rd_addr_phase", {29'd0, cs, we, oe}, 32'h4);
        chk("rd_addr1", {28'd0, sram_address}, {28'd0, a});
        tick();                                  // edge 2
        chk("rd_data_phase", {29'd0, cs, we, oe}, 32'h5);
        chk("rd_addr2", {28'd0, sram_address}, {28'd0, a});
        chk("rd_early", {31'd0, rsp_valid}, 32'd0);
        tick();                                  // edge 3
        chk("rd_latency", {31'd0, rsp_valid}, 32'd1);
        get_rsp(exp, stall);
    endtask

    typedef struct {
        bit               wr;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;   // write data, or expected read data
        int               stall;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int waited, cyc, last, i;
        vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 0};
        vecs[1]  = '{1'b0, 4'd3,  32'hDEADBEEF, 0};
        vecs[2]  = '{1'b1, 4'd5,  32'h12345678, 0};
        vecs[3]  = '{1'b0, 4'd5,  32'h12345678, 6};
        vecs[4]  = '{1'b1, 4'd7,  32'hA5A5A5A5, 0};
        vecs[5]  = '{1'b0, 4'd7,  32'hA5A5A5A5, 1};
        vecs[6]  = '{1'b1, 4'd0,  32'h00000000, 0};
        vecs[7]  = '{1'b0, 4'd0,  32'h00000000, 0};
        vecs[8]  = '{1'b1, 4'd15, 32'hFFFFFFFF, 0};
        vecs[9]  = '{1'b0, 4'd15, 32'hFFFFFFFF, 0};
        vecs[10] = '{1'b1, 4'd3,  32'h0BADF00D, 0};
        vecs[11] = '{1'b0, 4'd3,  32'h0BADF00D, 0};
        vecs[12] = '{1'b0, 4'd5,  32'h12345678, 2};

        for (int k = 0; k < DEPTH; k++) begin
            sram_mem[k] = 32'h0;
            ref_mem[k]  = 32'h0;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ctrl", {29'd0, cs, we, oe}, 32'd0);
        chk("rst_addr", {28'd0, sram_address}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].wr) begin
                do_write(vecs[v].addr, vecs[v].data, waited);
            end else begin
                chk("vec_model", ref_mem[vecs[v].addr], vecs[v].data);
                do_read(vecs[v].addr, vecs[v].stall);
            end
        end

        // back-to-back writes with req_valid held
        req_valid = 1'b1; req_write = 1'b1; rsp_ready = 1'b1;
        cyc = 0; last = -1; i = 0;
        while (i < DEPTH && cyc < 200) begin
            req_addr  = AW'(i);
            req_wdata = i * 32'h01010101;
            if (req_ready) begin
                if (last >= 0) chk("b2b_gap", cyc - last, WR_GAP);
                last = cyc;
                ref_mem[i] = i * 32'h01010101;
                i++;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b_count", i, DEPTH);
        repeat (3) tick();
        rsp_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) do_read(AW'(k), 0);

        // randomized mix against the reference memory
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 1) do_write(AW'($urandom_range(0, DEPTH - 1)), $urandom, waited);
            else                           do_read(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 3));
        end

        // reset while the SRAM drives the bus
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
        wait_ready("rst_rd", waited);
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_oe", {31'd0, oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_ctrl", {29'd0, cs, we, oe}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_write(4'd9, 32'hC0FFEE01, waited);
        chk("post_rst_first_accept", waited, 0);
        do_read(4'd9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end
endmodule
